i2s_rx: RTL
===========

# i2s_rx

Captures serial ADC audio from the SGTL5000 codec over I2S and presents it as stereo sample pairs on a valid/ready handshake. The codec is the I2S master and drives sclk, lrclk and din. This block oversamples those pins in the 50 MHz system domain, frames the left and right words, and hands one {left, right} pair per frame to the SoC-side consumer. It is the receive counterpart of the dout path already wired to ARDUINO_IO[2].

## Interface
- DATA_WIDTH, 16: bits captured per channel, MSB first. Valid range 8–32.
- SYNC_STAGES, 2: synchronizer flops per input pin. Minimum 2.
- Clk  input  1  50 MHz system clock (MAX10_CLK1_50).
- Reset  input  1  asynchronous, active-high reset.
- enable  input  1  when low, the FSM is held in SYNC and no samples are produced.
- sclk  input  1  I2S bit clock from the codec, asynchronous to Clk.
- lrclk  input  1  I2S word select from the codec: 0 = left, 1 = right.
- din  input  1  I2S serial data from the codec.
- sample_left  output  DATA_WIDTH  left word of the held pair.
- sample_right  output  DATA_WIDTH  right word of the held pair.
- sample_valid  output  1  the held pair is valid.
- sample_ready  input  1  the consumer accepts the pair.
- overrun  output  1  sticky: a completed pair was dropped.
- frame_err  output  1  sticky: a channel slot was shorter than DATA_WIDTH.
- err_clr  input  1  synchronous clear of overrun and frame_err.

## Operation
- sclk, lrclk and din each pass through a SYNC_STAGES-deep synchronizer. All three have identical depth, so their mutual alignment is preserved.
- sclk_rise is a one-Clk pulse on a 0→1 transition of synced sclk. All framing work happens only on sclk_rise cycles.
- lr_prev holds the lrclk value sampled at the previous sclk_rise. An lr edge is synced lrclk ≠ lr_prev at the current sclk_rise.
- The din bit on the lr-edge rise is the previous slot's trailing bit (I2S one-bit delay) and is discarded. The next DATA_WIDTH rises shift din into shreg, MSB first.
- FSM states:
  - SYNC: wait for an lr edge to 0 (start of a left slot); then go to SHIFT with chan=0 and bit_cnt=0. This is the entry state after reset and whenever enable is low.
  - SHIFT: on each rise with no lr edge, shift din in and increment bit_cnt. When bit_cnt reaches DATA_WIDTH, store the word and go to WAIT.
    - If chan=0, the word goes to left_hold.
    - If chan=1, the pair is committed to the output register.
  - WAIT: ignore surplus slot bits until an lr edge. On that edge, set chan to the new lrclk, clear bit_cnt and return to SHIFT.
- Short slot: an lr edge in SHIFT before DATA_WIDTH bits have arrived sets frame_err and discards the partial word. If the new lrclk=0, restart SHIFT as a left slot; otherwise go to SYNC.
- A right slot completing without a left word captured since the last commit is discarded. This occurs only after a frame_err.
- Commit to the output register:
  - If sample_valid=0, or sample_valid=1 with sample_ready=1 in the same cycle, load {left_hold, shreg} and set sample_valid=1.
  - Otherwise keep the held pair and set overrun.
- Handshake: the transfer happens on a Clk edge with sample_valid & sample_ready. sample_valid clears unless a commit occurs in that same cycle. Output data is stable while sample_valid=1 and sample_ready=0.
- err_clr clears both sticky flags. If a set event and err_clr coincide, the set wins.
- enable falling mid-frame: go to SYNC immediately and discard partial words. An already-held output pair is kept.

## Timing
- Reset values: sample_left=0, sample_right=0, sample_valid=0, overrun=0, frame_err=0, FSM=SYNC, lr_prev=1, shreg=0, bit_cnt=0.
- Latency: sample_valid asserts SYNC_STAGES+2 Clk cycles after the codec's sclk rising edge that carries the right-channel LSB.
- sclk must be ≤ Clk/8 (6.25 MHz). The codec runs at 64·fs, 2.82 MHz at 44.1 kHz.
- Throughput: one pair per lrclk period. The consumer has an entire frame to respond before overrun.
- Widths: bit_cnt is $clog2(DATA_WIDTH+1) bits and saturates at DATA_WIDTH in WAIT. Slots longer than DATA_WIDTH are legal.

## Structure
- Package i2s_pkg contains:
  - the typedef enum logic [1:0] {SYNC, SHIFT, WAIT} i2s_rx_state_t;
  - the localparam I2S_DEFAULT_WIDTH = 16;
  - a sample_pair_t struct {left, right}, shared with the transmit side.
- Sub-module i2s_sync is a parameterized synchronizer plus rise/fall detector. It is instantiated once per pin; only the sclk instance uses the edge outputs.

## Test plan
- Reset, then 64·fs frames with left=16'hA5C3 and right=16'h0F0F, sample_ready=1 → first pair {A5C3, 0F0F} appears, one valid pulse per frame, no flags.
- sample_ready held 0 across two frames (pair 1111/2222, then 3333/4444) → the output holds {1111, 2222}, overrun=1 after the second frame, and the data is unchanged until ready rises.
- A left slot of only 10 sclk cycles → frame_err=1, no pair for that frame, and the next full frame is received correctly. err_clr then clears the flag.
- Reset asserted mid-SHIFT (after 7 bits) → all outputs are 0 immediately (asynchronous). The first pair after release comes from the first complete frame that starts on the left slot.
- lrclk stuck high after reset → the FSM stays in SYNC and sample_valid stays 0. After the first lrclk fall, capture begins.
- DATA_WIDTH=24 with 32-bit slots and left=24'h800001 → sample_left=24'h800001; the 8 surplus bits are ignored.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S types: receive FSM states, default word width and the stereo pair.
package i2s_pkg;

  localparam int I2S_DEFAULT_WIDTH = 16;
  localparam int I2S_MAX_WIDTH     = 32;

  typedef enum logic [1:0] {SYNC, SHIFT, WAIT} i2s_rx_state_t;

  typedef struct packed {
    logic [I2S_MAX_WIDTH-1:0] left;
    logic [I2S_MAX_WIDTH-1:0] right;
  } sample_pair_t;

endpackage

// File: rtl/i2s_sync.sv
// Multi-flop synchronizer for one codec pin with registered rise/fall pulses.
// q is delayed one extra flop so it lines up with the edge pulses.
module i2s_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic dly_q, dly_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    dly_d  = sync_q[STAGES-1];
    rise_d = sync_q[STAGES-1] & ~dly_q;
    fall_d = ~sync_q[STAGES-1] & dly_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q    = dly_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples codec sclk/lrclk/din in the system clock domain
// and presents one {left, right} pair per frame on a valid/ready handshake.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = I2S_DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  enable,
  input  logic                  sclk,
  input  logic                  lrclk,
  input  logic                  din,
  output logic [DATA_WIDTH-1:0] sample_left,
  output logic [DATA_WIDTH-1:0] sample_right,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  output logic                  frame_err,
  input  logic                  err_clr
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic sclk_rise, lr_s, din_s;
  logic unused_sclk_q, unused_sclk_fall;
  logic unused_lr_rise, unused_lr_fall, unused_din_rise, unused_din_fall;

  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(Clk), .rst(Reset), .d(sclk),
    .q(unused_sclk_q), .rise(sclk_rise), .fall(unused_sclk_fall)
  );
  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_lr (
    .clk(Clk), .rst(Reset), .d(lrclk),
    .q(lr_s), .rise(unused_lr_rise), .fall(unused_lr_fall)
  );
  i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_din (
    .clk(Clk), .rst(Reset), .d(din),
    .q(din_s), .rise(unused_din_rise), .fall(unused_din_fall)
  );

  i2s_rx_state_t        state_q, state_d;
  logic                 chan_q, chan_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                 lr_prev_q, lr_prev_d;
  logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                 left_ok_q, left_ok_d;
  logic [DATA_WIDTH-1:0] out_left_q, out_left_d;
  logic [DATA_WIDTH-1:0] out_right_q, out_right_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic                 ferr_q, ferr_d;

  logic [DATA_WIDTH-1:0] shift_nxt;
  logic [CW-1:0]         cnt_nxt;
  logic                  lr_edge, xfer, commit, set_ovr, set_ferr;

  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    lr_prev_d   = lr_prev_q;
    left_hold_d = left_hold_q;
    left_ok_d   = left_ok_q;
    out_left_d  = out_left_q;
    out_right_d = out_right_q;
    valid_d     = valid_q;
    commit      = 1'b0;
    set_ovr     = 1'b0;
    set_ferr    = 1'b0;

    shift_nxt = {shreg_q[DATA_WIDTH-2:0], din_s};
    cnt_nxt   = bit_cnt_q + CW'(1);
    lr_edge   = sclk_rise && (lr_s != lr_prev_q);
    xfer      = valid_q & sample_ready;

    if (sclk_rise) lr_prev_d = lr_s;

    if (!enable) begin
      state_d   = SYNC;
      bit_cnt_d = '0;
      left_ok_d = 1'b0;
    end else if (sclk_rise) begin
      unique case (state_q)
        SYNC: begin
          if (lr_edge && !lr_s) begin
            state_d   = SHIFT;
            chan_d    = 1'b0;
            bit_cnt_d = '0;
          end
        end
        SHIFT: begin
          if (lr_edge) begin
            // Slot ended early: the partial word is dropped.
            set_ferr  = 1'b1;
            bit_cnt_d = '0;
            chan_d    = 1'b0;
            if (!lr_s) begin
              state_d   = SHIFT;
              left_ok_d = 1'b0;
            end else begin
              state_d = SYNC;
            end
          end else begin
            shreg_d   = shift_nxt;
            bit_cnt_d = cnt_nxt;
            if (cnt_nxt == CW'(DATA_WIDTH)) begin
              state_d = WAIT;
              if (!chan_q) begin
                left_hold_d = shift_nxt;
                left_ok_d   = 1'b1;
              end else if (left_ok_q) begin
                commit    = 1'b1;
                left_ok_d = 1'b0;
              end
            end
          end
        end
        WAIT: begin
          if (lr_edge) begin
            state_d   = SHIFT;
            chan_d    = lr_s;
            bit_cnt_d = '0;
          end
        end
        default: state_d = SYNC;
      endcase
    end

    if (commit) begin
      if (!valid_q || xfer) begin
        out_left_d  = left_hold_q;
        out_right_d = shift_nxt;
        valid_d     = 1'b1;
      end else begin
        set_ovr = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
    end

    ovr_d  = set_ovr  | (ovr_q  & ~err_clr);
    ferr_d = set_ferr | (ferr_q & ~err_clr);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= SYNC;
      chan_q      <= 1'b0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      lr_prev_q   <= 1'b1;
      left_hold_q <= '0;
      left_ok_q   <= 1'b0;
      out_left_q  <= '0;
      out_right_q <= '0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      lr_prev_q   <= lr_prev_d;
      left_hold_q <= left_hold_d;
      left_ok_q   <= left_ok_d;
      out_left_q  <= out_left_d;
      out_right_q <= out_right_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign sample_left  = out_left_q;
  assign sample_right = out_right_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  assign frame_err    = ferr_q;

endmodule
